// File: rtl/riscv_pkg.sv
// Shared RV32 definitions for the fetch slice.
// Word/instruction types and the IF/ID bundle.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam int IM_DEPTH_DEF = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef logic [XLEN-1:0] instr_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
        instr_t          instr;
        logic            valid;
    } if_id_t;

endpackage

// File: rtl/fetch_stage_pc_reg.sv
// PC register with next-PC selection.
// Priority: rst > redirect > stall > pc+4.
module pc_reg
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_target_i,
    output logic [XLEN-1:0] pc_o,
    output logic            misalign_err_o
);

    logic [XLEN-1:0] pc_d, pc_q;
    logic            misalign_d, misalign_q;

    // Next PC: redirect is force-aligned, stall holds, else sequential
    always_comb begin
        pc_d       = pc_q + 32'd4;
        misalign_d = misalign_q;
        if (redirect_i) begin
            pc_d = {redirect_target_i[XLEN-1:2], 2'b00};
            if (redirect_target_i[1:0] != 2'b00) begin
                misalign_d = 1'b1;
            end
        end else if (stall_i) begin
            pc_d = pc_q;
        end
    end

    // PC and sticky misalign flag
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
        end
    end

    assign pc_o           = pc_q;
    assign misalign_err_o = misalign_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: drives IM index, owns IF/ID register
// and the valid-fetch counter; PC lives in pc_reg.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter int              IM_DEPTH  = IM_DEPTH_DEF,
    parameter instr_t          NOP_INSTR = riscv_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_target_i,
    output logic [15:0]     im_addr_o,
    input  instr_t          im_instr_i,
    output logic [XLEN-1:0] ifid_pc_o,
    output logic [XLEN-1:0] ifid_pc4_o,
    output instr_t          ifid_instr_o,
    output logic            ifid_valid_o,
    output logic            misalign_err_o,
    output logic [XLEN-1:0] fetch_count_o
);

    localparam logic [30:0] DEPTH = 31'(IM_DEPTH);

    logic [XLEN-1:0] pc;
    logic            in_range;
    if_id_t          ifid_d, ifid_q;
    logic [XLEN-1:0] count_d, count_q;

    pc_reg #(
        .RESET_PC(RESET_PC)
    ) u_pc_reg (
        .clk               (clk),
        .rst               (rst),
        .stall_i           (stall_i),
        .redirect_i        (redirect_i),
        .redirect_target_i (redirect_target_i),
        .pc_o              (pc),
        .misalign_err_o    (misalign_err_o)
    );

    assign im_addr_o = pc[17:2];
    assign in_range  = ({1'b0, pc[XLEN-1:2]} < DEPTH);

    // IF/ID load, flush on redirect, hold on stall; count valid loads
    always_comb begin
        ifid_d  = ifid_q;
        count_d = count_q;
        if (redirect_i) begin
            ifid_d.instr = NOP_INSTR;
            ifid_d.valid = 1'b0;
        end else if (!stall_i) begin
            ifid_d.pc    = pc;
            ifid_d.pc4   = pc + 32'd4;
            ifid_d.instr = in_range ? im_instr_i : NOP_INSTR;
            ifid_d.valid = in_range;
            if (in_range) begin
                count_d = count_q + 32'd1;
            end
        end
    end

    // IF/ID pipeline register and fetch counter
    always_ff @(posedge clk) begin
        if (rst) begin
            ifid_q.pc    <= '0;
            ifid_q.pc4   <= '0;
            ifid_q.instr <= NOP_INSTR;
            ifid_q.valid <= 1'b0;
            count_q      <= '0;
        end else begin
            ifid_q  <= ifid_d;
            count_q <= count_d;
        end
    end

    assign ifid_pc_o     = ifid_q.pc;
    assign ifid_pc4_o    = ifid_q.pc4;
    assign ifid_instr_o  = ifid_q.instr;
    assign ifid_valid_o  = ifid_q.valid;
    assign fetch_count_o = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a 32-word IM model.
// Outputs are sampled 1ns after each rising edge.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_target_i;
    logic [15:0] im_addr_o;
    logic [31:0] im_instr_i;
    logic [31:0] ifid_pc_o;
    logic [31:0] ifid_pc4_o;
    logic [31:0] ifid_instr_o;
    logic        ifid_valid_o;
    logic        misalign_err_o;
    logic [31:0] fetch_count_o;

    logic [31:0] mem [32];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // IM model: combinational read, garbage beyond depth
    always_comb begin
        im_instr_i = 32'hDEAD_BEEF;
        if (im_addr_o < 16'd32) begin
            im_instr_i = mem[im_addr_o[4:0]];
        end
    end

    fetch_stage dut (
        .clk               (clk),
        .rst               (rst),
        .stall_i           (stall_i),
        .redirect_i        (redirect_i),
        .redirect_target_i (redirect_target_i),
        .im_addr_o         (im_addr_o),
        .im_instr_i        (im_instr_i),
        .ifid_pc_o         (ifid_pc_o),
        .ifid_pc4_o        (ifid_pc4_o),
        .ifid_instr_o      (ifid_instr_o),
        .ifid_valid_o      (ifid_valid_o),
        .misalign_err_o    (misalign_err_o),
        .fetch_count_o     (fetch_count_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ifid(input string tag, input logic [31:0] pc,
                            input logic [31:0] instr, input logic v,
                            input logic [31:0] cnt);
        chk({tag, ".pc"}, ifid_pc_o, pc);
        chk({tag, ".pc4"}, ifid_pc4_o, pc + 32'd4);
        chk({tag, ".instr"}, ifid_instr_o, instr);
        chk({tag, ".valid"}, {31'd0, ifid_valid_o}, {31'd0, v});
        chk({tag, ".cnt"}, fetch_count_o, cnt);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            mem[i] = 32'hA000_0000 + 32'(i);
        end
        mem[0] = 32'h0000_0293;
        mem[1] = 32'h0000_0393;
        mem[2] = 32'h0010_0313;

        rst = 1'b1;
        stall_i = 1'b0;
        redirect_i = 1'b0;
        redirect_target_i = '0;
        step();
        step();

        // reset state
        chk("rst.im_addr", 32'(im_addr_o), 32'd0);
        chk("rst.pc", ifid_pc_o, 32'd0);
        chk("rst.pc4", ifid_pc4_o, 32'd0);
        chk("rst.instr", ifid_instr_o, NOP);
        chk("rst.valid", {31'd0, ifid_valid_o}, 32'd0);
        chk("rst.mis", {31'd0, misalign_err_o}, 32'd0);
        chk("rst.cnt", fetch_count_o, 32'd0);

        // sequential fetch
        rst = 1'b0;
        step();
        chk("seq0.im_addr", 32'(im_addr_o), 32'd1);
        chk_ifid("seq0", 32'h0, 32'h0000_0293, 1'b1, 32'd1);
        step();
        chk("seq1.im_addr", 32'(im_addr_o), 32'd2);
        chk_ifid("seq1", 32'h4, 32'h0000_0393, 1'b1, 32'd2);

        // stall 3 cycles at pc=0x08
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall.im_addr", 32'(im_addr_o), 32'd2);
            chk_ifid("stall", 32'h4, 32'h0000_0393, 1'b1, 32'd2);
        end
        stall_i = 1'b0;
        step();
        chk("resume.im_addr", 32'(im_addr_o), 32'd3);
        chk_ifid("resume", 32'h8, 32'h0010_0313, 1'b1, 32'd3);
        step();
        chk_ifid("seq3", 32'hC, mem[3], 1'b1, 32'd4);
        chk("seq3.im_addr", 32'(im_addr_o), 32'd4);

        // redirect to 0x34 from pc=0x10
        redirect_i = 1'b1;
        redirect_target_i = 32'h34;
        step();
        redirect_i = 1'b0;
        chk("redir.im_addr", 32'(im_addr_o), 32'h0D);
        chk_ifid("redir", 32'hC, NOP, 1'b0, 32'd4);
        step();
        chk_ifid("redir1", 32'h34, mem[13], 1'b1, 32'd5);
        chk("redir1.im_addr", 32'(im_addr_o), 32'h0E);

        // stall and redirect together: redirect wins
        stall_i = 1'b1;
        redirect_i = 1'b1;
        redirect_target_i = 32'h20;
        step();
        stall_i = 1'b0;
        redirect_i = 1'b0;
        chk("sr.im_addr", 32'(im_addr_o), 32'h08);
        chk_ifid("sr", 32'h34, NOP, 1'b0, 32'd5);
        chk("sr.mis", {31'd0, misalign_err_o}, 32'd0);
        step();
        chk_ifid("sr1", 32'h20, mem[8], 1'b1, 32'd6);

        // misaligned redirect to 0x06
        redirect_i = 1'b1;
        redirect_target_i = 32'h06;
        step();
        redirect_i = 1'b0;
        chk("mis.im_addr", 32'(im_addr_o), 32'h01);
        chk("mis.flag", {31'd0, misalign_err_o}, 32'd1);
        step();
        chk_ifid("mis1", 32'h4, 32'h0000_0393, 1'b1, 32'd7);
        step();
        step();
        chk("mis.sticky", {31'd0, misalign_err_o}, 32'd1);

        // end of IM: 0x7C valid, 0x80 invalid
        redirect_i = 1'b1;
        redirect_target_i = 32'h78;
        step();
        redirect_i = 1'b0;
        chk("end.im_addr", 32'(im_addr_o), 32'h1E);
        step();
        chk_ifid("end78", 32'h78, mem[30], 1'b1, 32'd10);
        step();
        chk_ifid("end7c", 32'h7C, mem[31], 1'b1, 32'd11);
        chk("end7c.im_addr", 32'(im_addr_o), 32'h20);
        step();
        chk_ifid("end80", 32'h80, NOP, 1'b0, 32'd11);
        chk("end80.im_addr", 32'(im_addr_o), 32'h21);

        // reset asserted mid-stall
        stall_i = 1'b1;
        step();
        chk_ifid("hold", 32'h80, NOP, 1'b0, 32'd11);
        rst = 1'b1;
        step();
        chk("mrst.im_addr", 32'(im_addr_o), 32'd0);
        chk("mrst.pc", ifid_pc_o, 32'd0);
        chk("mrst.pc4", ifid_pc4_o, 32'd0);
        chk("mrst.instr", ifid_instr_o, NOP);
        chk("mrst.valid", {31'd0, ifid_valid_o}, 32'd0);
        chk("mrst.mis", {31'd0, misalign_err_o}, 32'd0);
        chk("mrst.cnt", fetch_count_o, 32'd0);
        rst = 1'b0;
        stall_i = 1'b0;
        step();
        chk_ifid("post", 32'h0, 32'h0000_0293, 1'b1, 32'd1);

        // PC wrap at top of address space
        redirect_i = 1'b1;
        redirect_target_i = 32'hFFFF_FFFC;
        step();
        redirect_i = 1'b0;
        chk("wrap.im_addr", 32'(im_addr_o), 32'h0000_FFFF);
        step();
        chk("wrap.pc", ifid_pc_o, 32'hFFFF_FFFC);
        chk("wrap.pc4", ifid_pc4_o, 32'h0);
        chk("wrap.instr", ifid_instr_o, NOP);
        chk("wrap.valid", {31'd0, ifid_valid_o}, 32'd0);
        chk("wrap.cnt", fetch_count_o, 32'd1);
        chk("wrap.im_addr1", 32'(im_addr_o), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
